// File: rtl/gemmm2s_pkt_fifo_if.sv
// AXI-Stream link used on both sides of gemmm2s_pkt_fifo: 32-bit TDATA, TLAST,
// and the TVALID/TREADY handshake.
interface gemmm2s_pkt_fifo_if;
    logic [31:0] TDATA;
    logic        TLAST;
    logic        TVALID;
    logic        TREADY;

    modport master (output TDATA, TLAST, TVALID, input TREADY);
    modport slave  (input TDATA, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/gemmm2s_pkt_fifo.sv
// Store-and-forward packet FIFO behind the gemmm2s bridge: a packet is released
// only after its TLAST is stored. Define GEMMM2S_PKT_FIFO_DROP_EN to drop oversized packets.
module gemmm2s_pkt_fifo #(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    gemmm2s_pkt_fifo_if.slave     S_AXIS,
    gemmm2s_pkt_fifo_if.master    M_AXIS,
    output logic [DEPTH_LOG2:0]   PKT_COUNT,
    output logic [15:0]           DROP_COUNT
);
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] DEPTH_W = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [32:0]   mem [DEPTH];
    logic [32:0]   ram_q;
    logic          ram_v_q, ram_v_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          out_v_q, out_v_d;
    logic          rdy_en_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [PW-1:0] occ;
    logic          full, tready, wr_en, pkt_inc, pkt_dec;
    logic          m_hs, move, fetch;

`ifdef GEMMM2S_PKT_FIFO_DROP_EN
    typedef enum logic {ST_ACCEPT, ST_DROP} state_e;
    state_e        state_q, state_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
`endif

    // rd_ptr frees space only on the M handshake, so words sitting in the read
    // pipeline still count as occupied; fetch_ptr is the RAM read address.
    assign occ  = wr_ptr_q - rd_ptr_q;
    assign full = (occ == DEPTH_W);

    assign m_hs  = out_v_q && M_AXIS.TREADY;
    assign move  = ram_v_q && (!out_v_q || M_AXIS.TREADY);
    assign fetch = (fetch_ptr_q != commit_ptr_q) && (!ram_v_q || move);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        pkt_inc      = 1'b0;
        tready       = rdy_en_q && !full;
        wr_en        = 1'b0;
`ifdef GEMMM2S_PKT_FIFO_DROP_EN
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        if (state_q == ST_DROP) begin
            tready = 1'b1;
            if (S_AXIS.TVALID && S_AXIS.TLAST) begin
                state_d = ST_ACCEPT;
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (rdy_en_q && full && S_AXIS.TVALID) begin
            state_d  = ST_DROP;
            wr_ptr_d = commit_ptr_q;
        end else begin
            wr_en = S_AXIS.TVALID && tready;
        end
`else
        wr_en = S_AXIS.TVALID && tready;
`endif
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (S_AXIS.TLAST) begin
                commit_ptr_d = wr_ptr_q + 1'b1;
                pkt_inc      = 1'b1;
            end
        end
    end

    always_comb begin
        fetch_ptr_d = fetch ? fetch_ptr_q + 1'b1 : fetch_ptr_q;
        rd_ptr_d    = m_hs ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ram_v_d     = ram_v_q;
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        pkt_dec     = m_hs && out_last_q;
        if (fetch)     ram_v_d = 1'b1;
        else if (move) ram_v_d = 1'b0;
        if (move) begin
            out_v_d    = 1'b1;
            out_data_d = ram_q[31:0];
            out_last_d = ram_q[32];
        end else if (m_hs) begin
            out_v_d = 1'b0;
        end
        unique case ({pkt_inc, pkt_dec})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (wr_en) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {S_AXIS.TLAST, S_AXIS.TDATA};
        if (fetch) ram_q <= mem[fetch_ptr_q[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            fetch_ptr_q  <= '0;
            rd_ptr_q     <= '0;
            pkt_cnt_q    <= '0;
            ram_v_q      <= 1'b0;
            out_v_q      <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            fetch_ptr_q  <= fetch_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_cnt_q    <= pkt_cnt_d;
            ram_v_q      <= ram_v_d;
            out_v_q      <= out_v_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            rdy_en_q     <= 1'b1;
        end
    end

`ifdef GEMMM2S_PKT_FIFO_DROP_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= ST_ACCEPT;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
    assign DROP_COUNT = drop_cnt_q;
`else
    assign DROP_COUNT = '0;
`endif

    assign S_AXIS.TREADY = tready;
    assign M_AXIS.TVALID = out_v_q;
    assign M_AXIS.TDATA  = out_data_q;
    assign M_AXIS.TLAST  = out_last_q;
    assign PKT_COUNT     = pkt_cnt_q;
endmodule

// File: tb/tb_gemmm2s_pkt_fifo.sv
// Directed and throttled-random bench for gemmm2s_pkt_fifo at DEPTH_LOG2 = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_gemmm2s_pkt_fifo;
    localparam int unsigned DL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DL:0]   pkt_count;
    logic [15:0]   drop_count;
    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [32:0]   exp_q [$];

    gemmm2s_pkt_fifo_if s_if ();
    gemmm2s_pkt_fifo_if m_if ();

    always #5 clk = ~clk;

    gemmm2s_pkt_fifo #(.DEPTH_LOG2(DL)) dut (
        .ACLK       (clk),
        .ARESETN    (rst_n),
        .S_AXIS     (s_if),
        .M_AXIS     (m_if),
        .PKT_COUNT  (pkt_count),
        .DROP_COUNT (drop_count)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        s_if.TVALID = 1'b0; s_if.TDATA = '0; s_if.TLAST = 1'b0;
        m_if.TREADY = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (s_if.TREADY !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", s_if.TREADY); end
        checks++; if (m_if.TVALID !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_if.TVALID); end
        checks++; if (m_if.TDATA !== 32'h0) begin errors++; $display("FAIL rst_tdata: got %h want 0", m_if.TDATA); end
        checks++; if (m_if.TLAST !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", m_if.TLAST); end
        checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop_count: got %0d want 0", drop_count); end
        rst_n = 1'b1;
        #1;
        checks++; if (s_if.TREADY !== 1'b0) begin errors++; $display("FAIL rel_tready_early: got %b want 0", s_if.TREADY); end
        @(negedge clk);
        checks++; if (s_if.TREADY !== 1'b1) begin errors++; $display("FAIL rel_tready: got %b want 1", s_if.TREADY); end
        checks++; if (m_if.TVALID !== 1'b0) begin errors++; $display("FAIL rel_tvalid: got %b want 0", m_if.TVALID); end
    endtask

    task automatic test_single_packet();
        m_if.TREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_if.TVALID = 1'b1; s_if.TDATA = 32'(i); s_if.TLAST = (i == 3);
            @(negedge clk);
        end
        s_if.TVALID = 1'b0; s_if.TLAST = 1'b0;
        checks++; if (pkt_count !== 5'd1) begin errors++; $display("FAIL single_commit: got %0d want 1", pkt_count); end
        checks++; if (m_if.TVALID !== 1'b0) begin errors++; $display("FAIL single_lat0: got %b want 0", m_if.TVALID); end
        @(negedge clk);
        checks++; if (m_if.TVALID !== 1'b0) begin errors++; $display("FAIL single_lat1: got %b want 0", m_if.TVALID); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++; if (m_if.TVALID !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b want 1", i, m_if.TVALID); end
            checks++; if (m_if.TDATA !== 32'(i)) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", i, m_if.TDATA, i); end
            checks++; if (m_if.TLAST !== (i == 3)) begin errors++; $display("FAIL single_last[%0d]: got %b want %b", i, m_if.TLAST, (i == 3)); end
            @(negedge clk);
        end
        checks++; if (m_if.TVALID !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", m_if.TVALID); end
        checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL single_pkt_done: got %0d want 0", pkt_count); end
    endtask

    task automatic test_gap();
        int unsigned guard;
        m_if.TREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_if.TVALID = 1'b1; s_if.TDATA = 32'h10 + 32'(i); s_if.TLAST = 1'b0;
            @(negedge clk);
        end
        s_if.TVALID = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (m_if.TVALID !== 1'b0) begin errors++; $display("FAIL gap_hold[%0d]: got %b want 0", i, m_if.TVALID); end
        end
        checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL gap_pkt: got %0d want 0", pkt_count); end
        s_if.TVALID = 1'b1; s_if.TDATA = 32'h13; s_if.TLAST = 1'b1;
        @(negedge clk);
        s_if.TVALID = 1'b0; s_if.TLAST = 1'b0;
        guard = 0;
        while (m_if.TVALID !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
        checks++; if (guard >= 10) begin errors++; $display("FAIL gap_timeout: got no TVALID want TVALID within 10 cycles"); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (m_if.TDATA !== 32'h10 + 32'(i) || m_if.TVALID !== 1'b1) begin errors++; $display("FAIL gap_data[%0d]: got %h want %h", i, m_if.TDATA, 32'h10 + 32'(i)); end
            checks++; if (m_if.TLAST !== (i == 3)) begin errors++; $display("FAIL gap_last[%0d]: got %b want %b", i, m_if.TLAST, (i == 3)); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp [5];
        exp = '{{1'b0, 32'h20}, {1'b0, 32'h21}, {1'b1, 32'h22}, {1'b0, 32'h30}, {1'b1, 32'h31}};
        m_if.TREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_if.TVALID = 1'b1; s_if.TLAST = exp[i][32]; s_if.TDATA = exp[i][31:0];
            @(negedge clk);
        end
        s_if.TVALID = 1'b0; s_if.TLAST = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pkt_count !== 5'd2) begin errors++; $display("FAIL b2b_pkt: got %0d want 2", pkt_count); end
        m_if.TREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (m_if.TVALID !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, m_if.TVALID); end
            checks++; if ({m_if.TLAST, m_if.TDATA} !== exp[i]) begin errors++; $display("FAIL b2b_word[%0d]: got %h want %h", i, {m_if.TLAST, m_if.TDATA}, exp[i]); end
            @(negedge clk);
        end
        checks++; if (m_if.TVALID !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", m_if.TVALID); end
    endtask

    task automatic test_full();
        int unsigned guard;
        m_if.TREADY = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (s_if.TREADY !== 1'b1) begin errors++; $display("FAIL full_tready_pre[%0d]: got %b want 1", i, s_if.TREADY); end
            s_if.TVALID = 1'b1; s_if.TDATA = 32'h100 + 32'(i); s_if.TLAST = 1'b1;
            @(negedge clk);
        end
        s_if.TVALID = 1'b0;
        checks++; if (s_if.TREADY !== 1'b0) begin errors++; $display("FAIL full_tready: got %b want 0", s_if.TREADY); end
        checks++; if (pkt_count !== 5'd16) begin errors++; $display("FAIL full_pkt: got %0d want 16", pkt_count); end
        s_if.TVALID = 1'b1; s_if.TDATA = 32'hDEAD; s_if.TLAST = 1'b1;
        repeat (3) @(negedge clk);
        s_if.TVALID = 1'b0;
        checks++; if (s_if.TREADY !== 1'b0) begin errors++; $display("FAIL full_hold: got %b want 0", s_if.TREADY); end
        checks++; if (pkt_count !== 5'd16) begin errors++; $display("FAIL full_pkt_hold: got %0d want 16", pkt_count); end
        checks++; if (m_if.TVALID !== 1'b1 || m_if.TDATA !== 32'h100) begin errors++; $display("FAIL full_head: got %b/%h want 1/100", m_if.TVALID, m_if.TDATA); end
        m_if.TREADY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            guard = 0;
            while (m_if.TVALID !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
            checks++; if (m_if.TVALID !== 1'b1 || m_if.TDATA !== 32'h100 + 32'(i) || m_if.TLAST !== 1'b1) begin
                errors++; $display("FAIL full_drain[%0d]: got %b/%h want 1/%h", i, m_if.TVALID, m_if.TDATA, 32'h100 + 32'(i));
            end
            @(negedge clk);
        end
        checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL full_pkt_end: got %0d want 0", pkt_count); end
        checks++; if (s_if.TREADY !== 1'b1) begin errors++; $display("FAIL full_tready_end: got %b want 1", s_if.TREADY); end
    endtask

    task automatic test_random();
        int unsigned lens [1000];
        int unsigned total;
        total = 0;
        for (int p = 0; p < 1000; p++) begin
            lens[p] = $urandom_range(1, 16);
            total += lens[p];
        end
        fork
            begin
                int unsigned guard;
                for (int p = 0; p < 1000; p++) begin
                    for (int w = 0; w < int'(lens[p]); w++) begin
                        s_if.TVALID = 1'b0;
                        while ($urandom_range(0, 3) == 0) @(negedge clk);
                        s_if.TDATA = (32'(p) << 16) | 32'(w);
                        s_if.TLAST = (w == int'(lens[p]) - 1);
                        s_if.TVALID = 1'b1;
                        guard = 0;
                        while (s_if.TREADY !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
                        if (guard >= 1000) begin
                            errors++; $display("FAIL rand_src_stall: got TREADY 0 for 1000 cycles want 1");
                        end
                        exp_q.push_back({s_if.TLAST, s_if.TDATA});
                        @(negedge clk);
                    end
                end
                s_if.TVALID = 1'b0;
            end
            begin
                int unsigned got, cyc;
                logic        stalled, in_pkt;
                logic [32:0] held, want;
                got = 0; cyc = 0; stalled = 1'b0; in_pkt = 1'b0; held = '0;
                while (got < total && cyc < 60000) begin
                    m_if.TREADY = ($urandom_range(0, 3) != 0);
                    if (stalled) begin
                        checks++; if (m_if.TVALID !== 1'b1 || {m_if.TLAST, m_if.TDATA} !== held) begin
                            errors++; $display("FAIL rand_stable: got %b/%h want 1/%h", m_if.TVALID, {m_if.TLAST, m_if.TDATA}, held);
                        end
                    end
                    if (in_pkt) begin
                        checks++; if (m_if.TVALID !== 1'b1) begin errors++; $display("FAIL rand_midpkt_gap: got TVALID %b want 1", m_if.TVALID); end
                    end
                    if (m_if.TVALID === 1'b1 && m_if.TREADY) begin
                        want = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0_DEAD_BEEF;
                        checks++; if ({m_if.TLAST, m_if.TDATA} !== want) begin
                            errors++; $display("FAIL rand_word[%0d]: got %h want %h", got, {m_if.TLAST, m_if.TDATA}, want);
                        end
                        in_pkt = !m_if.TLAST;
                        stalled = 1'b0;
                        got++;
                    end else begin
                        stalled = (m_if.TVALID === 1'b1);
                        held = {m_if.TLAST, m_if.TDATA};
                    end
                    @(negedge clk);
                    cyc++;
                end
                checks++; if (got != total) begin errors++; $display("FAIL rand_count: got %0d words want %0d", got, total); end
            end
        join
        m_if.TREADY = 1'b1;
        @(negedge clk);
        checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL rand_pkt_end: got %0d want 0", pkt_count); end
    endtask

    task automatic test_overflow();
        int unsigned guard;
        m_if.TREADY = 1'b1;
`ifdef GEMMM2S_PKT_FIFO_DROP_EN
        begin
            int unsigned run, max_run;
            logic        seen_valid;
            run = 0; max_run = 0; guard = 0; seen_valid = 1'b0;
            for (int i = 0; i < 20; i++) begin
                s_if.TVALID = 1'b1; s_if.TDATA = 32'h200 + 32'(i); s_if.TLAST = (i == 19);
                run = 0;
                while (s_if.TREADY !== 1'b1 && guard < 50) begin
                    run++; guard++;
                    if (run > max_run) max_run = run;
                    @(negedge clk);
                end
                @(negedge clk);
                if (m_if.TVALID === 1'b1) seen_valid = 1'b1;
            end
            s_if.TVALID = 1'b0; s_if.TLAST = 1'b0;
            checks++; if (max_run != 1) begin errors++; $display("FAIL drop_tready_low: got %0d cycles want 1", max_run); end
            checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_count: got %0d want 1", drop_count); end
            checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL drop_pkt: got %0d want 0", pkt_count); end
            checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL drop_leak: got TVALID during drop want none"); end
            for (int i = 0; i < 4; i++) begin
                s_if.TVALID = 1'b1; s_if.TDATA = 32'h300 + 32'(i); s_if.TLAST = (i == 3);
                @(negedge clk);
            end
            s_if.TVALID = 1'b0; s_if.TLAST = 1'b0;
            for (int i = 0; i < 4; i++) begin
                guard = 0;
                while (m_if.TVALID !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
                checks++; if (m_if.TVALID !== 1'b1 || m_if.TDATA !== 32'h300 + 32'(i) || m_if.TLAST !== (i == 3)) begin
                    errors++; $display("FAIL drop_next[%0d]: got %b/%h want 1/%h", i, m_if.TVALID, m_if.TDATA, 32'h300 + 32'(i));
                end
                @(negedge clk);
            end
        end
`else
        for (int i = 0; i < 16; i++) begin
            checks++; if (s_if.TREADY !== 1'b1) begin errors++; $display("FAIL ovf_tready_pre[%0d]: got %b want 1", i, s_if.TREADY); end
            s_if.TVALID = 1'b1; s_if.TDATA = 32'h200 + 32'(i); s_if.TLAST = 1'b0;
            @(negedge clk);
        end
        s_if.TDATA = 32'h210;
        guard = 0;
        for (int i = 0; i < 20; i++) begin
            if (s_if.TREADY !== 1'b0) guard++;
            @(negedge clk);
        end
        s_if.TVALID = 1'b0;
        checks++; if (guard != 0) begin errors++; $display("FAIL ovf_tready: got %0d ready cycles want 0", guard); end
        checks++; if (m_if.TVALID !== 1'b0) begin errors++; $display("FAIL ovf_tvalid: got %b want 0", m_if.TVALID); end
        checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL ovf_pkt: got %0d want 0", pkt_count); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL ovf_drop_count: got %0d want 0", drop_count); end
`endif
    endtask

    task automatic test_reset_mid();
        s_if.TVALID = 1'b1; s_if.TDATA = 32'h400; s_if.TLAST = 1'b0;
        @(negedge clk);
        s_if.TVALID = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (s_if.TREADY !== 1'b0) begin errors++; $display("FAIL mid_rst_tready: got %b want 0", s_if.TREADY); end
        checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL mid_rst_pkt: got %0d want 0", pkt_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_if.TREADY !== 1'b1) begin errors++; $display("FAIL mid_rel_tready: got %b want 1", s_if.TREADY); end
        checks++; if (m_if.TVALID !== 1'b0) begin errors++; $display("FAIL mid_rel_tvalid: got %b want 0", m_if.TVALID); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_gap();
        test_back_to_back();
        test_full();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
